// File: rtl/param_sum_latch.sv
// Serial WIDTH-bit adder/subtractor/accumulator. It processes SLICE bits per clock
// and holds the (WIDTH+1)-bit result until the consumer completes the handshake.
module param_sum_latch #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       mode_r;
  logic             carry_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] part_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH:0]   sum_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             idle_r;

  logic [SLICE-1:0] a_sl_s;
  logic [SLICE-1:0] b_sl_s;
  logic [SLICE:0]   slice_s;
  logic [WIDTH-1:0] res_s;
  logic             last_s;
  logic             cin_msb_s;
  logic             ovf_s;

  assign in_ready  = idle_r & ~rst;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign overflow  = ovf_r;
  assign busy      = busy_r;

  // Current slice add and the full result as it would look after this slice
  always_comb begin
    a_sl_s  = a_r[idx_r*SLICE +: SLICE];
    b_sl_s  = b_r[idx_r*SLICE +: SLICE];
    slice_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_r};
    res_s   = part_r;
    res_s[idx_r*SLICE +: SLICE] = slice_s[SLICE-1:0];
    last_s  = (idx_r == IW'(N - 1));
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits
    cin_msb_s = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ res_s[WIDTH-1];
    ovf_s     = cin_msb_s ^ slice_s[SLICE];
  end

  // Control FSM, operand latching, serial datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      mode_r      <= 2'b00;
      carry_r     <= 1'b0;
      idx_r       <= {IW{1'b0}};
      part_r      <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      sum_r       <= {(WIDTH+1){1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      idle_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            mode_r <= mode;
            idx_r  <= {IW{1'b0}};
            part_r <= {WIDTH{1'b0}};
            case (mode)
              MODE_ADD: begin
                a_r     <= op_a;
                b_r     <= op_b;
                carry_r <= 1'b0;
              end
              MODE_SUB: begin
                a_r     <= op_a;
                b_r     <= ~op_b;
                carry_r <= 1'b1;
              end
              MODE_ACC: begin
                a_r     <= acc_r;
                b_r     <= op_a;
                carry_r <= 1'b0;
              end
              MODE_CLR: begin
                a_r     <= {WIDTH{1'b0}};
                b_r     <= {WIDTH{1'b0}};
                carry_r <= 1'b0;
              end
              default: begin
                a_r     <= {WIDTH{1'b0}};
                b_r     <= {WIDTH{1'b0}};
                carry_r <= 1'b0;
              end
            endcase
            state_r <= ST_CALC;
            busy_r  <= 1'b1;
            idle_r  <= 1'b0;
          end
        end
        ST_CALC: begin
          part_r  <= res_s;
          carry_r <= slice_s[SLICE];
          idx_r   <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          if (last_s) begin
            // Subtraction reports borrow, the inverse of the final carry
            sum_r <= {(mode_r == MODE_SUB) ? ~slice_s[SLICE] : slice_s[SLICE], res_s};
            ovf_r <= ovf_s;
            if (mode_r[1]) begin
              acc_r <= res_s;
            end
            state_r     <= ST_HOLD;
            out_valid_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            idle_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          idle_r      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/param_sum_latch.md
Name: param_sum_latch

Overview:
Parametrised successor to the 4-bit combinational adder: a WIDTH-bit adder/subtractor/accumulator.
- Computes the result serially, SLICE bits per clock.
- Latches the operands on a valid/ready handshake.
- Holds the (WIDTH+1)-bit result until the downstream consumer (latch/UART TX path) takes it.
- Adds subtract, signed-overflow and running-accumulator modes, which the 4-bit block lacks.

Parameters:
WIDTH, 8, operand width in bits; must be ≥ 2.
SLICE, 4, bits processed per CALC cycle; WIDTH must be an integer multiple of SLICE.
N (localparam), WIDTH/SLICE, number of CALC cycles per operation.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  operands and mode presented.
in_ready  output  1  block can accept an operation (IDLE state and rst low).
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
mode  input  2  00 add, 01 sub, 10 accumulate, 11 clear accumulator.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
sum  output  WIDTH+1  result; bit WIDTH is carry (add/acc) or borrow (sub).
overflow  output  1  two's-complement overflow of the low WIDTH bits.
busy  output  1  high in CALC or HOLD.

Behaviour:
- One clock domain. Reset is synchronous and active-high: clock and reset ports are clk and rst; polarity and synchronicity are fixed.
- Reset (rst high at a rising edge), in any state including mid-CALC or HOLD, produces:
  - state IDLE, out_valid 0, sum 0, overflow 0, busy 0;
  - accumulator 0, slice index 0;
  - any in-flight operation discarded with no output;
  - in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- States and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready at an edge:
    - latch op_a, op_b and mode; later input changes are ignored;
    - for mode 01, latch B as ~op_b and set carry-in 1; otherwise carry-in 0;
    - for mode 10, replace operand A by the accumulator and operand B by op_a;
    - for mode 11, treat both operands as 0;
    - clear the slice index; go to CALC.
  - CALC: each edge adds slice k (bits k*SLICE..k*SLICE+SLICE-1) of A and B plus the registered carry. The partial sum goes into an internal register (not sum) and the carry is registered. After slice N-1, the same edge:
    - loads sum, overflow and (modes 10/11) the accumulator;
    - goes to HOLD.
    - out_valid rises exactly N edges after the accepting edge.
  - HOLD: out_valid=1; sum and overflow are stable. On out_valid & out_ready, go to IDLE with out_valid 0 at the next cycle. in_ready becomes 1 that cycle, so the minimum issue interval is N+2 cycles.
- Arithmetic:
  - sum[WIDTH-1:0] is the low bits of the result.
  - sum[WIDTH] is the final carry for add/acc, and the inverted carry (borrow; 1 when op_a < op_b unsigned) for sub.
  - overflow = carry into MSB XOR carry out of MSB.
  - Mode 11 yields sum 0 and overflow 0.
  - Accumulator update: acc ← sum[WIDTH-1:0] (wraps modulo 2^WIDTH; the carry is reported but not stored).
- sum and overflow keep their last value through IDLE and CALC until the next completion.
- in_valid is ignored outside IDLE; no input buffering.
- A simultaneous out_ready in the completing CALC cycle has no effect; the handshake is only in HOLD.
- out_ready held high continuously: HOLD lasts exactly one cycle.

Test Plan:
1. WIDTH=8, SLICE=4: reset, add 0xFF+0x01 → out_valid exactly 2 edges after accept, sum=0x100, overflow=0; in_ready=0 until the cycle after the out handshake.
2. Sub 0x05−0x07 → sum=0x1FE, overflow=0. Sub 0x80−0x01 → sum=0x07F, overflow=1. Add 0x7F+0x01 → sum=0x080, overflow=1.
3. Accumulate: clear (sum=0x000), then mode 10 with op_a=0x70 three times → sums 0x070, 0x0E0, 0x150. The accumulator then holds 0x50, and the next +0x10 gives 0x060.
4. Backpressure: hold out_ready=0 for 5 cycles in HOLD while toggling op_a/op_b/in_valid → sum and out_valid stable, in_ready=0, no operation accepted; release → next operation uses operands presented after release.
5. Reset mid-CALC (after 1 slice) and in HOLD → next cycle out_valid=0, sum=0, accumulator 0 (a following mode 10 with 0x03 gives 0x003), in_ready=1 after rst falls.
6. WIDTH=4, SLICE=1: all 4 modes × 256 operand pairs vs reference model, latency exactly 4 edges each, random out_ready stalls.
